// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl -- pipeline hazard / memory-wait controller for the 5-stage core
//
// Drives the stall and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB
// pipeline registers. It also provides the EX-stage operand forwarding selects,
// sequences multi-cycle data-memory accesses through a req/ack handshake with
// a timeout, resolves branches taken in MEM, and counts stalled cycles.
//
// Ports
//   clk, reset                 clock (rising edge), synchronous active-low reset
//   rsD, rtD                   ID-stage source registers
//   rsE, rtE                   EX-stage source registers
//   writeregE/M/W, RegWriteE/M/W  per-stage destination register and write enable
//   MemtoRegE                  EX instruction is a load
//   MemtoRegM, MemWriteM       MEM instruction is a load / store
//   BranchM, zeroM             branch in MEM and its ALU zero flag
//   mem_ack                    data memory done (level)
//   mem_req                    data memory request
//   stallF/D/E/M               hold PC, IF/ID, ID/EX, EX/MEM
//   flushD/E/M                 clear IF/ID, ID/EX, EX/MEM
//   bubbleW                    clear MEM/WB
//   pcsrcM                     select the branch target PC
//   forwardAE/BE               00 regfile, 01 WB result, 10 MEM aluout
//   mem_err                    sticky memory-timeout error
//   stall_cnt                  saturating count of cycles with stallF=1
// ============================================================================

// ----------------------------------------------------------------------------
// hazard_fwd -- forwarding select for one EX operand. MEM takes precedence
// over WB because it holds the younger result. Register 0 is never forwarded.
// ----------------------------------------------------------------------------
module hazard_fwd (
    input  logic [4:0] src,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] sel
);
    logic hit_m, hit_w;

    assign hit_m = RegWriteM && (writeregM != 5'd0) && (writeregM == src);
    assign hit_w = RegWriteW && (writeregW != 5'd0) && (writeregW == src);
    assign sel   = hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);
endmodule

// ----------------------------------------------------------------------------
// hazard_ctrl -- top
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int TIMEOUT = 16,   // max MEM_WAIT cycles before error, 1..255
    parameter int CNTW    = 16    // width of stall_cnt
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rsD,
    input  logic [4:0]      rtD,
    input  logic [4:0]      rsE,
    input  logic [4:0]      rtE,
    input  logic [4:0]      writeregE,
    input  logic [4:0]      writeregM,
    input  logic [4:0]      writeregW,
    input  logic            RegWriteE,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic            MemtoRegE,
    input  logic            MemtoRegM,
    input  logic            MemWriteM,
    input  logic            BranchM,
    input  logic            zeroM,
    input  logic            mem_ack,
    output logic            mem_req,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            stallM,
    output logic            flushD,
    output logic            flushE,
    output logic            flushM,
    output logic            bubbleW,
    output logic            pcsrcM,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            mem_err,
    output logic [CNTW-1:0] stall_cnt
);
    localparam int         NUM_OPS = 2;             // operand A (rs), B (rt)
    localparam logic [7:0] TMO     = 8'(TIMEOUT);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t     state, state_next;
    logic [7:0] tcnt, tcnt_next;

    logic memopM;
    logic lu;
    logic taken;

    // ------------------------------------------------------------------------
    // Forwarding: one hazard_fwd per EX operand
    // ------------------------------------------------------------------------
    logic [NUM_OPS-1:0][4:0] src_e;
    logic [NUM_OPS-1:0][1:0] fwd_sel;

    assign src_e[0] = rsE;
    assign src_e[1] = rtE;

    genvar g;
    generate
        for (g = 0; g < NUM_OPS; g++) begin : g_fwd
            hazard_fwd u_fwd (
                .src       (src_e[g]),
                .writeregM (writeregM),
                .writeregW (writeregW),
                .RegWriteM (RegWriteM),
                .RegWriteW (RegWriteW),
                .sel       (fwd_sel[g])
            );
        end
    endgenerate

    // Forward selects are combinational outputs and so also go quiet in reset.
    assign forwardAE = reset ? fwd_sel[0] : 2'b00;
    assign forwardBE = reset ? fwd_sel[1] : 2'b00;

    // ------------------------------------------------------------------------
    // Hazard terms
    // ------------------------------------------------------------------------
    assign memopM = MemtoRegM | MemWriteM;
    assign taken  = BranchM & zeroM;
    assign lu     = MemtoRegE && RegWriteE && (writeregE != 5'd0) &&
                    ((writeregE == rsD) || (writeregE == rtD));

    // ------------------------------------------------------------------------
    // State register, sticky error, stall counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            tcnt      <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            tcnt  <= tcnt_next;
            if (state_next == ERR)
                mem_err <= 1'b1;
            if (stallF && (stall_cnt != {CNTW{1'b1}}))
                stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------------
    // Next state and control outputs. Priority inside a state:
    // memory stall > taken branch > load-use.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        tcnt_next  = tcnt;
        mem_req    = 1'b0;
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        stallM     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        flushM     = 1'b0;
        bubbleW    = 1'b0;
        pcsrcM     = 1'b0;

        if (reset) begin
            case (state)
                RUN: begin
                    mem_req = memopM;
                    if (memopM && !mem_ack) begin
                        // First cycle of a multi-cycle access: freeze the
                        // whole front of the pipe and keep WB empty.
                        stallF     = 1'b1;
                        stallD     = 1'b1;
                        stallE     = 1'b1;
                        stallM     = 1'b1;
                        bubbleW    = 1'b1;
                        state_next = MEM_WAIT;
                        tcnt_next  = 8'd1;
                    end else if (taken) begin
                        // Wrong-path instructions in IF/ID, ID/EX, EX/MEM
                        // are discarded; any load-use stall is moot.
                        pcsrcM = 1'b1;
                        flushD = 1'b1;
                        flushE = 1'b1;
                        flushM = 1'b1;
                    end else if (lu) begin
                        // Hold the dependent instruction in ID one cycle and
                        // send a bubble down into EX.
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushE = 1'b1;
                    end
                end

                MEM_WAIT: begin
                    mem_req = 1'b1;
                    stallF  = 1'b1;
                    stallD  = 1'b1;
                    stallE  = 1'b1;
                    stallM  = 1'b1;
                    // On the ack cycle the access result is let into MEM/WB
                    // while everything upstream is still held.
                    bubbleW = !mem_ack;
                    if (mem_ack) begin
                        state_next = RUN;
                        tcnt_next  = 8'd0;
                    end else if (tcnt == TMO) begin
                        state_next = ERR;
                    end else begin
                        tcnt_next = tcnt + 8'd1;
                    end
                end

                ERR: begin
                    // Pipeline frozen until reset; request withdrawn.
                    stallF  = 1'b1;
                    stallD  = 1'b1;
                    stallE  = 1'b1;
                    stallM  = 1'b1;
                    bubbleW = 1'b1;
                end

                default: begin
                    state_next = RUN;
                    tcnt_next  = 8'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl
//
// Directed steps for each scenario, then randomized cycles. Every cycle all
// outputs are compared against a reference model that tracks only the number
// of consecutive unacknowledged request cycles, the sticky error flag and the
// stall count.
// ============================================================================
module tb_hazard_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CNTW    = 4;
    localparam int CMAX    = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic            RegWriteE, RegWriteM, RegWriteW;
    logic            MemtoRegE, MemtoRegM, MemWriteM, BranchM, zeroM, mem_ack;
    logic            mem_req, stallF, stallD, stallE, stallM;
    logic            flushD, flushE, flushM, bubbleW, pcsrcM, mem_err;
    logic [1:0]      forwardAE, forwardBE;
    logic [CNTW-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int pend;   // consecutive request cycles so far without ack
    bit err;    // timeout has happened since last reset
    int cnt;    // expected stall_cnt

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .BranchM(BranchM), .zeroM(zeroM), .mem_ack(mem_ack),
        .mem_req(mem_req), .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .bubbleW(bubbleW), .pcsrcM(pcsrcM), .forwardAE(forwardAE),
        .forwardBE(forwardBE), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] r);
        if (RegWriteM && writeregM != 0 && writeregM == r) return 2'b10;
        if (RegWriteW && writeregW != 0 && writeregW == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
        {MemtoRegM, MemWriteM, BranchM, zeroM, mem_ack} = '0;
    endtask

    // Inputs are already applied (1 time unit after a rising edge). Check
    // every output mid-cycle, advance the model, move to the next cycle.
    task automatic step();
        logic e_req, e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fM, e_bW, e_pc;
        logic [1:0] e_fa, e_fb;
        bit memop, lu;
        #3;
        {e_req, e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_fM, e_bW, e_pc} = '0;
        e_fa = 2'b00;
        e_fb = 2'b00;
        if (reset) begin
            memop = MemtoRegM || MemWriteM;
            lu = MemtoRegE && RegWriteE && writeregE != 0 &&
                 (writeregE == rsD || writeregE == rtD);
            e_fa = fwd_ref(rsE);
            e_fb = fwd_ref(rtE);
            if (err) begin
                {e_sF, e_sD, e_sE, e_sM, e_bW} = '1;
            end else if (pend > 0 || (memop && !mem_ack)) begin
                // An access is outstanding (or starts and is not acked now).
                e_req = 1'b1;
                {e_sF, e_sD, e_sE, e_sM} = '1;
                e_bW = !mem_ack;
            end else begin
                e_req = memop;
                if (BranchM && zeroM) {e_pc, e_fD, e_fE, e_fM} = '1;
                else if (lu) {e_sF, e_sD, e_fE} = '1;
            end
        end
        chk("mem_req", mem_req, e_req);
        chk("stallF", stallF, e_sF);
        chk("stallD", stallD, e_sD);
        chk("stallE", stallE, e_sE);
        chk("stallM", stallM, e_sM);
        chk("flushD", flushD, e_fD);
        chk("flushE", flushE, e_fE);
        chk("flushM", flushM, e_fM);
        chk("bubbleW", bubbleW, e_bW);
        chk("pcsrcM", pcsrcM, e_pc);
        chk("forwardAE", forwardAE, e_fa);
        chk("forwardBE", forwardBE, e_fb);
        chk("mem_err", mem_err, err);
        chk("stall_cnt", stall_cnt, cnt);

        if (!reset) begin
            pend = 0;
            err  = 0;
            cnt  = 0;
        end else begin
            if (e_sF) cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
            if (!err && e_req && e_sF) begin
                if (mem_ack) pend = 0;
                else if (pend + 1 > TIMEOUT) begin err = 1; pend = 0; end
                else pend = pend + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs(input int ack_pct);
        rsD = 5'($urandom_range(0, 3));  rtD = 5'($urandom_range(0, 3));
        rsE = 5'($urandom_range(0, 3));  rtE = 5'($urandom_range(0, 3));
        writeregE = 5'($urandom_range(0, 3));
        writeregM = 5'($urandom_range(0, 3));
        writeregW = 5'($urandom_range(0, 3));
        RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
        MemtoRegE = 1'($urandom);
        MemtoRegM = ($urandom_range(0, 3) == 0);
        MemWriteM = ($urandom_range(0, 5) == 0);
        BranchM   = ($urandom_range(0, 3) == 0);
        zeroM     = 1'($urandom);
        mem_ack   = ($urandom_range(0, 99) < ack_pct);
        reset     = ($urandom_range(0, 79) != 0);
    endtask

    initial begin
        pend = 0; err = 0; cnt = 0;
        clear_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        // Reset with active-looking inputs: outputs must stay quiet.
        rand_inputs(50); reset = 1'b0; MemtoRegM = 1'b1; mem_ack = 1'b0; step();
        rand_inputs(50); reset = 1'b0; step();
        reset = 1'b1; clear_inputs();

        // Load-use
        MemtoRegE = 1; RegWriteE = 1; writeregE = 5'd8; rsD = 5'd8; step();
        clear_inputs(); step();
        chk("lu_stall_cnt", stall_cnt, 1);
        MemtoRegE = 1; RegWriteE = 1; writeregE = 5'd0; rsD = 5'd0; step();
        clear_inputs();

        // Forwarding
        writeregM = 5'd9; writeregW = 5'd9; RegWriteM = 1; RegWriteW = 1; rsE = 5'd9; step();
        RegWriteM = 0; step();
        RegWriteM = 1; writeregM = 5'd0; rtE = 5'd9; #3;
        chk("fwdB_wb", forwardBE, 2'b01);
        chk("fwdA_wb", forwardAE, 2'b01);
        @(posedge clk); #1;
        clear_inputs();

        // Memory wait: ack on the third request cycle
        MemtoRegM = 1; step(); step();
        mem_ack = 1; step();
        clear_inputs(); step();
        chk("memwait_stall_cnt", stall_cnt, 4);

        // Branch beats load-use
        MemtoRegE = 1; RegWriteE = 1; writeregE = 5'd5; rtD = 5'd5;
        BranchM = 1; zeroM = 1; step();
        clear_inputs();

        // Timeout into ERR, then recover with reset
        MemtoRegM = 1;
        for (int i = 0; i < 7; i++) step();
        chk("timeout_err", mem_err, 1'b1);
        reset = 0; step();
        reset = 1; clear_inputs(); step();
        chk("err_cleared", mem_err, 1'b0);

        // Reset in the middle of a wait; late ack ignored
        MemtoRegM = 1; step(); step();
        reset = 0; step();
        reset = 1; MemtoRegM = 0; mem_ack = 1; step();
        mem_ack = 0; step();

        // Randomized: alternate ack-heavy and ack-starved phases
        for (int ph = 0; ph < 12; ph++) begin
            for (int i = 0; i < 250; i++) begin
                rand_inputs((ph % 3 == 2) ? 5 : 60);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
